// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcode/funct constants, FSM states and
// datapath mux/ALU select encodings used by the multicycle controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGIC = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REGA   = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_R31 = 2'b10
  } reg_dst_t;

endpackage

// File: rtl/mc_stall_timer.sv
// Memory stall counter with optional timeout for the multicycle controller.
module mc_stall_timer #(
  parameter int unsigned STALL_LIMIT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int unsigned LIM_M1_I = (STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1;
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIM_M1_I);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on state change, otherwise count stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Timeout fires in the stalled cycle that brings the count to the limit
  always_comb begin
    timeout = (STALL_LIMIT != 0) && inc && (cnt_q == LIM_M1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath through
// fetch/decode/execute/memory/writeback with a mem_req/mem_ready handshake.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] operation,
  input  logic [5:0] function_number,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_operation,
  output logic       noExt,
  output logic [1:0] reg_dst,
  output logic       memtoreg,
  output logic       jal,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   mem_req_c, mem_write_c, ir_write_c, pc_en_c, reg_write_c;
  logic   timeout;

  mc_stall_timer #(
    .STALL_LIMIT(STALL_LIMIT),
    .CNT_W      (CNT_W)
  ) u_stall_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_d != state_q),
    .inc    (mem_req_c & ~mem_ready),
    .timeout(timeout)
  );

  // Next-state and sticky error flag logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (operation)
          OP_RTYPE:               state_d = (function_number == FN_JR) ? S_JR : S_EXEC;
          OP_LW, OP_SW:           state_d = S_MEMADR;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_J, OP_JAL:           state_d = S_JUMP;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (operation == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD, S_MEMWR: begin
        if (mem_ready) state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JR: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Moore output decode; ir_write/pc_en additionally follow mem_ready/zero
  always_comb begin
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    pc_en_c       = 1'b0;
    reg_write_c   = 1'b0;
    iord          = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_operation = ALU_ADD;
    noExt         = 1'b0;
    reg_dst       = DST_RT;
    memtoreg      = 1'b0;
    jal           = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        memtoreg    = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        iord        = 1'b1;
      end
      S_EXEC: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst     = DST_RD;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_operation = ALU_SUB;
        pc_src        = PC_ALUOUT;
        pc_en_c       = zero;
      end
      S_IEXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_IMM;
        alu_operation = (operation == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
        noExt         = (operation == OP_ORI);
      end
      S_IWB: reg_write_c = 1'b1;
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_en_c = 1'b1;
        if (operation == OP_JAL) begin
          reg_write_c = 1'b1;
          reg_dst     = DST_R31;
          jal         = 1'b1;
        end
      end
      S_JR: begin
        pc_src  = PC_REGA;
        pc_en_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst_n so a reset mid-access drops them immediately
  always_comb begin
    mem_req    = rst_n & mem_req_c;
    mem_write  = rst_n & mem_write_c;
    ir_write   = rst_n & ir_write_c;
    pc_en      = rst_n & pc_en_c;
    reg_write  = rst_n & reg_write_c;
    illegal_op = illegal_q;
    bus_err    = bus_err_q;
    state_o    = state_q;
  end

  // State and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction streams with
// random memory stalls, checked against per-instruction state sequences.
module tb_multicycle_ctrl;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                 MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, IEXEC = 9,
                 IWB = 10, JUMP = 11, JRS = 12, TRAP = 13;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101,
                         LUI = 6'b001111, JOP = 6'b000010, JAL = 6'b000011,
                         JRF = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] operation, function_number;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b, alu_operation, reg_dst;
  logic       alu_src_a, noExt, memtoreg, jal, reg_write;
  logic       illegal_op, bus_err;
  logic [3:0] state_o;

  multicycle_ctrl #(.STALL_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation),
    .function_number(function_number), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_operation(alu_operation), .noExt(noExt), .reg_dst(reg_dst),
    .memtoreg(memtoreg), .jal(jal), .reg_write(reg_write),
    .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         st;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ill;
    logic       berr;
  } ent_t;

  ent_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected control vector, straight from the per-state output table
  function automatic logic [17:0] exp_out(ent_t e);
    logic req = 0, wr = 0, io = 0, irw = 0, pce = 0, sa = 0, ne = 0, m2r = 0, jl = 0, rw = 0;
    logic [1:0] ps = 0, sb = 0, ao = 0, rd = 0;
    case (e.st)
      FETCH:  begin req = 1; sb = 2'b01; irw = e.rdy; pce = e.rdy; end
      DECODE: sb = 2'b11;
      MEMADR: begin sa = 1; sb = 2'b10; end
      MEMRD:  begin req = 1; io = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin req = 1; wr = 1; io = 1; end
      EXEC:   begin sa = 1; ao = 2'b10; end
      ALUWB:  begin rw = 1; rd = 2'b01; end
      BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pce = e.z; end
      IEXEC:  begin sa = 1; sb = 2'b10; ao = (e.op == ADDI) ? 2'b00 : 2'b11; ne = (e.op == ORI); end
      IWB:    rw = 1;
      JUMP:   begin ps = 2'b10; pce = 1; if (e.op == JAL) begin rw = 1; rd = 2'b10; jl = 1; end end
      JRS:    begin ps = 2'b11; pce = 1; end
      default: ;
    endcase
    return {req, wr, io, irw, pce, ps, sa, sb, ao, ne, rd, m2r, jl, rw};
  endfunction

  task automatic push(input int st, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic z);
    ent_t e;
    e.st = st; e.rdy = rdy; e.op = op; e.fn = fn; e.z = z; e.ill = 0; e.berr = 0;
    q.push_back(e);
  endtask

  // Expand one instruction into its expected cycle-by-cycle state sequence
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int sf, input int sm, input logic z);
    for (int k = 0; k < sf; k++)
      push(FETCH, 1'b0, 6'($urandom), 6'($urandom), z);
    push(FETCH, 1'b1, 6'($urandom), 6'($urandom), z);
    push(DECODE, 1'($urandom), op, fn, z);
    case (op)
      RTYPE: if (fn == JRF) push(JRS, 1'($urandom), op, fn, z);
             else begin
               push(EXEC, 1'($urandom), op, fn, z);
               push(ALUWB, 1'($urandom), op, fn, z);
             end
      LW: begin
        push(MEMADR, 1'($urandom), op, fn, z);
        for (int k = 0; k < sm; k++) push(MEMRD, 1'b0, op, fn, z);
        push(MEMRD, 1'b1, op, fn, z);
        push(MEMWB, 1'($urandom), op, fn, z);
      end
      SW: begin
        push(MEMADR, 1'($urandom), op, fn, z);
        for (int k = 0; k < sm; k++) push(MEMWR, 1'b0, op, fn, z);
        push(MEMWR, 1'b1, op, fn, z);
      end
      BEQ: push(BRANCH, 1'($urandom), op, fn, z);
      ADDI, ORI, LUI: begin
        push(IEXEC, 1'($urandom), op, fn, z);
        push(IWB, 1'($urandom), op, fn, z);
      end
      default: push(JUMP, 1'($urandom), op, fn, z);
    endcase
  endtask

  task automatic drive(input ent_t e);
    operation = e.op; function_number = e.fn; zero = e.z; mem_ready = e.rdy;
  endtask

  task automatic check_cycle(input ent_t e);
    logic [17:0] obs;
    obs = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alu_operation, noExt, reg_dst, memtoreg, jal, reg_write};
    check($sformatf("state(op=%b)", e.op), 32'(state_o), 32'(e.st));
    check($sformatf("ctrl@st%0d", e.st), 32'(obs), 32'(exp_out(e)));
    check($sformatf("flags@st%0d", e.st), {30'd0, illegal_op, bus_err}, {30'd0, e.ill, e.berr});
  endtask

  task automatic play(input int n);
    ent_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      drive(e);
      #1;
      check_cycle(e);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rnd_stall();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops[10];
    logic [5:0] op, fn;
    int idx;
    ent_t e;
    ops = '{RTYPE, RTYPE, LW, SW, BEQ, ADDI, ORI, LUI, JOP, JAL};

    rst_n = 1'b0; operation = '0; function_number = '0; zero = 0; mem_ready = 1;
    #2;
    check("rst_state", 32'(state_o), 32'(FETCH));
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_pc_en", {30'd0, ir_write, pc_en}, 32'd0);
    check("rst_flags", {30'd0, illegal_op, bus_err}, 32'd0);
    #10;
    rst_n = 1'b1;

    add_instr(ADDI, 6'($urandom), 0, 0, 1'b0);
    add_instr(LW, 6'($urandom), 0, 3, 1'b0);
    add_instr(BEQ, 6'($urandom), 0, 0, 1'b1);
    add_instr(BEQ, 6'($urandom), 0, 0, 1'b0);
    add_instr(JAL, 6'($urandom), 0, 0, 1'b0);
    add_instr(RTYPE, JRF, 0, 0, 1'b0);
    add_instr(SW, 6'($urandom), 3, 3, 1'b1);
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(0, 9));
      op = ops[idx];
      fn = 6'($urandom);
      if (idx == 0 && fn == JRF) fn = 6'b100000;
      if (idx == 1) fn = JRF;
      add_instr(op, fn, rnd_stall(), rnd_stall(), 1'($urandom));
    end
    play(100000);

    // Reset in the middle of a stalled store
    add_instr(SW, 6'd0, 0, 2, 1'b0);
    play(3);
    q.delete();
    mem_ready = 1'b0;
    #1;
    check("memwr_before_rst", {30'd0, mem_req, mem_write}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_drops_mem_write", 32'(mem_write), 32'd0);
    check("rst_drops_mem_req", 32'(mem_req), 32'd0);
    check("rst_state_async", 32'(state_o), 32'(FETCH));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_state", 32'(state_o), 32'(FETCH));
    @(posedge clk);
    #1;
    check("post_rst_hold", 32'(state_o), 32'(FETCH));

    // Undefined opcode traps and stays trapped
    push(FETCH, 1'b1, 6'd0, 6'd0, 1'b0);
    push(DECODE, 1'b1, 6'b111111, 6'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push(TRAP, 1'b1, 6'b111111, 6'd0, 1'b1);
      q[q.size()-1].ill = 1'b1;
    end
    play(100);

    // Fetch stall timeout with limit 4
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) push(FETCH, 1'b0, 6'($urandom), 6'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push(TRAP, 1'($urandom), 6'($urandom), 6'd0, 1'b0);
      q[q.size()-1].berr = 1'b1;
    end
    play(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
